// File: rtl/demux_1to4_ctrl.sv
// demux_1to4_ctrl: byte-striping controller for the 1:4 DEMUX path.
// A serial byte stream is dealt round-robin onto lanes 0..3. Each group of four
// bytes is released on all lanes in a single cycle. A flush closes a partial group early.
// Optional feature macro DEMUX_SHORT_ERR_EN adds the short_err pulse and the
// saturating short_cnt counter for groups that were closed by a flush.

// Per-lane slice: holds one byte until its group is released, then drives the lane output.
module demux_1to4_lane #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cap,        // this lane takes data_in this cycle
  input  logic              emit,       // group released this cycle
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              hold_valid
);
  logic [DATA_W-1:0] hold;

  // Capture into hold, or on emit bypass the in-flight byte straight to the output.
  // On emit, a lane that was never filled is driven to zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold       <= '0;
      hold_valid <= 1'b0;
      data_out   <= '0;
      valid_out  <= 1'b0;
    end else if (emit) begin
      data_out   <= cap ? data_in : (hold_valid ? hold : '0);
      valid_out  <= cap | hold_valid;
      hold_valid <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (cap) begin
        hold       <= data_in;
        hold_valid <= 1'b1;
      end
    end
  end
endmodule

module demux_1to4_ctrl #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  input  logic              flush,
  output logic [DATA_W-1:0] data_out0,
  output logic [DATA_W-1:0] data_out1,
  output logic [DATA_W-1:0] data_out2,
  output logic [DATA_W-1:0] data_out3,
  output logic              valid_out0,
  output logic              valid_out1,
  output logic              valid_out2,
  output logic              valid_out3,
  output logic              group_done,
`ifdef DEMUX_SHORT_ERR_EN
  output logic              short_err,
  output logic [7:0]        short_cnt,
`endif
  output logic [1:0]        lane_ptr
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {S_L0, S_L1, S_L2, S_L3} state_t;

  state_t                             state_q, state_d;
  logic                               emit;
  logic [NUM_LANES-1:0]               cap;
  logic [NUM_LANES-1:0]               hv;
  logic [NUM_LANES-1:0]               lane_vld;
  logic [NUM_LANES-1:0][DATA_W-1:0]   lane_data;

  assign lane_ptr = state_q;

  // Lane pointer register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_L0;
    else        state_q <= state_d;
  end

  // Next lane and group-release decision. A byte arriving with a flush is included first.
  always_comb begin
    state_d = state_q;
    emit    = 1'b0;
    if (valid_in) begin
      emit = (state_q == S_L3) | flush;
      if (emit) state_d = S_L0;
      else begin
        case (state_q)
          S_L0:    state_d = S_L1;
          S_L1:    state_d = S_L2;
          S_L2:    state_d = S_L3;
          default: state_d = S_L0;
        endcase
      end
    end else if (flush && state_q != S_L0) begin
      emit    = 1'b1;
      state_d = S_L0;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign cap[i] = valid_in && (state_q == state_t'(2'(i)));
    demux_1to4_lane #(.DATA_W(DATA_W)) u_lane (
      .clk        (clk),
      .reset      (reset),
      .cap        (cap[i]),
      .emit       (emit),
      .data_in    (data_in),
      .data_out   (lane_data[i]),
      .valid_out  (lane_vld[i]),
      .hold_valid (hv[i])
    );
  end

  assign data_out0  = lane_data[0];
  assign data_out1  = lane_data[1];
  assign data_out2  = lane_data[2];
  assign data_out3  = lane_data[3];
  assign valid_out0 = lane_vld[0];
  assign valid_out1 = lane_vld[1];
  assign valid_out2 = lane_vld[2];
  assign valid_out3 = lane_vld[3];

  // group_done is registered alongside the lane outputs, so it pulses in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) group_done <= 1'b0;
    else        group_done <= emit;
  end

`ifdef DEMUX_SHORT_ERR_EN
  logic short_grp;
  assign short_grp = emit && !(&(hv | cap));

  // Flag groups that a flush closed with fewer than four lanes, and count them, saturating.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      short_err <= 1'b0;
      short_cnt <= '0;
    end else begin
      short_err <= short_grp;
      if (short_grp && short_cnt != 8'hFF) short_cnt <= short_cnt + 8'd1;
    end
  end
`endif
endmodule

// File: tb/tb_demux_1to4_ctrl.sv
// Randomized bench for demux_1to4_ctrl, checked against a queue-based group model.
module tb_demux_1to4_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       flush;
  logic [7:0] data_out0, data_out1, data_out2, data_out3;
  logic       valid_out0, valid_out1, valid_out2, valid_out3;
  logic       group_done;
  logic [1:0] lane_ptr;
`ifdef DEMUX_SHORT_ERR_EN
  logic       short_err;
  logic [7:0] short_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  // Reference model state: the bytes of the open group, and the expected outputs.
  logic [7:0] q[$];
  logic [7:0] e_data[4];
  logic       e_vld[4];
  logic       e_done;
  logic       e_short;
  int         e_cnt;

  demux_1to4_ctrl #(.DATA_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .flush      (flush),
    .data_out0  (data_out0),
    .data_out1  (data_out1),
    .data_out2  (data_out2),
    .data_out3  (data_out3),
    .valid_out0 (valid_out0),
    .valid_out1 (valid_out1),
    .valid_out2 (valid_out2),
    .valid_out3 (valid_out3),
    .group_done (group_done),
`ifdef DEMUX_SHORT_ERR_EN
    .short_err  (short_err),
    .short_cnt  (short_cnt),
`endif
    .lane_ptr   (lane_ptr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, " data0"}, 32'(data_out0), 32'(e_data[0]));
    chk({ph, " data1"}, 32'(data_out1), 32'(e_data[1]));
    chk({ph, " data2"}, 32'(data_out2), 32'(e_data[2]));
    chk({ph, " data3"}, 32'(data_out3), 32'(e_data[3]));
    chk({ph, " vld"}, 32'({valid_out3, valid_out2, valid_out1, valid_out0}),
        32'({e_vld[3], e_vld[2], e_vld[1], e_vld[0]}));
    chk({ph, " done"}, 32'(group_done), 32'(e_done));
    chk({ph, " ptr"}, 32'(lane_ptr), 32'(q.size()));
`ifdef DEMUX_SHORT_ERR_EN
    chk({ph, " short_err"}, 32'(short_err), 32'(e_short));
    chk({ph, " short_cnt"}, 32'(short_cnt), 32'(e_cnt));
`endif
  endtask

  function automatic void model_reset();
    q.delete();
    for (int i = 0; i < 4; i++) begin
      e_data[i] = 8'h00;
      e_vld[i]  = 1'b0;
    end
    e_done = 1'b0; e_short = 1'b0; e_cnt = 0;
  endfunction

  // One clock edge: a group is released when four bytes are collected, or when a flush
  // arrives with at least one byte collected (including the byte on this edge).
  function automatic void model_edge(input logic v, input logic [7:0] d, input logic f);
    if (v) q.push_back(d);
    if (q.size() == 4 || (f && q.size() > 0)) begin
      for (int i = 0; i < 4; i++) begin
        e_vld[i]  = (i < q.size());
        e_data[i] = (i < q.size()) ? q[i] : 8'h00;
      end
      e_done  = 1'b1;
      e_short = (q.size() < 4);
      if (e_short && e_cnt < 255) e_cnt++;
      q.delete();
    end else begin
      for (int i = 0; i < 4; i++) e_vld[i] = 1'b0;
      e_done  = 1'b0;
      e_short = 1'b0;
    end
  endfunction

  task automatic step(input logic v, input logic [7:0] d, input logic f, input string ph);
    valid_in = v; data_in = d; flush = f;
    @(posedge clk);
    model_edge(v, d, f);
    #1;
    check_all(ph);
    valid_in = 1'b0; flush = 1'b0;
  endtask

  // Asserted away from any edge; outputs must clear before the next edge arrives.
  task automatic do_reset(input string ph);
    reset = 1'b0;
    #1;
    model_reset();
    check_all({ph, " async"});
    @(posedge clk);
    #1;
    check_all({ph, " held"});
    reset = 1'b1;
  endtask

  initial begin
    logic [7:0] t2[4];
    reset = 1'b1; valid_in = 1'b0; flush = 1'b0; data_in = 8'h00;
    model_reset();
    #12;
    do_reset("T1");

    t2[0] = 8'hA1; t2[1] = 8'hB2; t2[2] = 8'hC3; t2[3] = 8'hD4;
    for (int i = 0; i < 4; i++) step(1'b1, t2[i], 1'b0, "T2");
    step(1'b0, 8'h00, 1'b0, "T2 idle");

    for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0, "T3");

    step(1'b1, 8'h11, 1'b0, "T4");
    step(1'b1, 8'h22, 1'b0, "T4");
    step(1'b0, 8'hEE, 1'b1, "T4 flush");
    step(1'b0, 8'h00, 1'b1, "flush empty");

    step(1'b1, 8'h31, 1'b0, "T5");
    step(1'b1, 8'h32, 1'b0, "T5");
    for (int i = 0; i < 3; i++) step(1'b0, 8'hFF, 1'b0, "T5 gap");
    step(1'b1, 8'h33, 1'b0, "T5");
    step(1'b1, 8'h34, 1'b0, "T5");

    step(1'b1, 8'h41, 1'b0, "flush3");
    step(1'b1, 8'h42, 1'b0, "flush3");
    step(1'b1, 8'h43, 1'b0, "flush3");
    step(1'b1, 8'h44, 1'b1, "flush full");
    step(1'b1, 8'h45, 1'b1, "flush one");

    step(1'b1, 8'h51, 1'b0, "T6");
    step(1'b1, 8'h52, 1'b0, "T6");
    do_reset("T6 rst");
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h55 + i), 1'b0, "T6");
    step(1'b0, 8'h00, 1'b0, "T6 idle");

`ifdef DEMUX_SHORT_ERR_EN
    // Drive enough single-byte groups to reach the saturation point of short_cnt.
    for (int i = 0; i < 260; i++) step(1'b1, 8'(i), 1'b1, "sat");
    step(1'b0, 8'h00, 1'b0, "sat idle");
`endif

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset("rnd rst");
      else step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) == 0, "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
